// File: rtl/preempt_arb_pkg.sv
// preempt_arb_pkg: shared definitions for preempt_arbiter.
//   STATE_W           width of the mstate encoding
//   ST_* constants    legacy numeric state encodings (IDLE=0 .. HI_PRE=3)
//   state_e           FSM state type built on those encodings
package preempt_arb_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_LO_ACT = 2'd1;
  localparam logic [STATE_W-1:0] ST_HI_ACT = 2'd2;
  localparam logic [STATE_W-1:0] ST_HI_PRE = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    LO_ACT = ST_LO_ACT,
    HI_ACT = ST_HI_ACT,
    HI_PRE = ST_HI_PRE
  } state_e;

endpackage

// File: rtl/preempt_arbiter_if.sv
// preempt_arbiter_if: request/grant bundle between the masters and the arbiter.
//   req, done       per-master level request / access-complete strobe
//   grant, owner    one-hot grant and index of the granted master
//   mstate          FSM state encoding
//   saved_valid/idx preempted low-priority master awaiting resume
//   nb_interrupts   saturating preemption count
// Modports: master = requester side, slave = arbiter side.
interface preempt_arbiter_if #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
);
  import preempt_arb_pkg::*;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] done;
  logic [N_MASTERS-1:0] grant;
  logic [IDX_W-1:0]     owner;
  logic [STATE_W-1:0]   mstate;
  logic                 saved_valid;
  logic [IDX_W-1:0]     saved_idx;
  logic [CNT_W-1:0]     nb_interrupts;

  modport master (
    output req, done,
    input  grant, owner, mstate, saved_valid, saved_idx, nb_interrupts
  );

  modport slave (
    input  req, done,
    output grant, owner, mstate, saved_valid, saved_idx, nb_interrupts
  );

endinterface

// File: rtl/preempt_arbiter_arb_pick.sv
// arb_pick: combinational selector among low-priority masters 1..N_MASTERS-1.
//   req_i    requests of masters N_MASTERS-1..1
//   ptr_i    round-robin search start (1..N_MASTERS-1)
//   valid_o  some low-priority master requests
//   idx_o    selected master index
// Macro PREEMPT_ARB_RR_EN: round-robin from ptr_i, wrapping N_MASTERS-1 -> 1;
// otherwise fixed priority, lowest index wins and ptr_i is unused.
module arb_pick #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:1] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

`ifdef PREEMPT_ARB_RR_EN
  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N_MASTERS - 1; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N_MASTERS) cand = cand - (N_MASTERS - 1);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = N_MASTERS - 1; k >= 1; k--) begin
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/preempt_arbiter.sv
// preempt_arbiter: N-master bus access controller. Master 0 preempts any
// low-priority tenure; the preempted master resumes automatically after it.
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    preempt_arbiter_if.slave (req/done in; grant, owner, mstate,
//          saved_valid, saved_idx, nb_interrupts out; all registered)
// Macro PREEMPT_ARB_RR_EN: round-robin among low-priority masters (adds a
// pointer register); undefined gives fixed lowest-index priority.
module preempt_arbiter
  import preempt_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned MIN_HOLD  = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  preempt_arbiter_if.slave bus
);

  localparam int unsigned      TEN_W   = $clog2(MIN_HOLD + 1);
  localparam logic [IDX_W-1:0] LAST_LO = IDX_W'(N_MASTERS - 1);
  localparam logic [IDX_W-1:0] FIRST_LO = IDX_W'(1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [TEN_W-1:0]     tenure_q, tenure_d;
  logic                 saved_valid_q, saved_valid_d;
  logic [IDX_W-1:0]     saved_idx_q, saved_idx_d;
  logic [CNT_W-1:0]     irq_q, irq_d;

  logic                 hold_met;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     pick_ptr;

`ifdef PREEMPT_ARB_RR_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = FIRST_LO;
`endif

  arb_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i   (bus.req[N_MASTERS-1:1]),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign hold_met = (tenure_q >= TEN_W'(MIN_HOLD));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    saved_valid_d = saved_valid_q;
    saved_idx_d   = saved_idx_q;
    irq_d         = irq_q;
    tenure_d      = tenure_q;
`ifdef PREEMPT_ARB_RR_EN
    ptr_d         = ptr_q;
`endif
    // Tenure counts up while granted and saturates at MIN_HOLD.
    if (state_q != IDLE && !hold_met) tenure_d = tenure_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.req[0]) begin
          state_d  = HI_ACT;
          owner_d  = '0;
          tenure_d = TEN_W'(1);
        end else if (pick_valid) begin
          state_d  = LO_ACT;
          owner_d  = pick_idx;
          tenure_d = TEN_W'(1);
`ifdef PREEMPT_ARB_RR_EN
          ptr_d    = (pick_idx == LAST_LO) ? FIRST_LO : pick_idx + 1'b1;
`endif
        end
      end
      LO_ACT: begin
        // Release has priority over preemption in the same cycle.
        if (bus.done[owner_q] && hold_met) begin
          owner_d  = '0;
          if (bus.req[0]) begin
            state_d  = HI_ACT;
            tenure_d = TEN_W'(1);
          end else begin
            state_d  = IDLE;
            tenure_d = '0;
          end
        end else if (bus.req[0]) begin
          state_d       = HI_PRE;
          owner_d       = '0;
          tenure_d      = TEN_W'(1);
          saved_valid_d = 1'b1;
          saved_idx_d   = owner_q;
          if (irq_q != '1) irq_d = irq_q + 1'b1;
        end
      end
      HI_ACT: begin
        if (bus.done[0] && hold_met) begin
          state_d  = IDLE;
          tenure_d = '0;
        end
      end
      HI_PRE: begin
        if (bus.done[0] && hold_met) begin
          saved_valid_d = 1'b0;
          if (bus.req[saved_idx_q]) begin
            state_d  = LO_ACT;
            owner_d  = saved_idx_q;
            tenure_d = TEN_W'(1);
          end else begin
            state_d  = IDLE;
            tenure_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = '0;
    if (state_d != IDLE) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      grant_q       <= '0;
      tenure_q      <= '0;
      saved_valid_q <= 1'b0;
      saved_idx_q   <= '0;
      irq_q         <= '0;
`ifdef PREEMPT_ARB_RR_EN
      ptr_q         <= FIRST_LO;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      tenure_q      <= tenure_d;
      saved_valid_q <= saved_valid_d;
      saved_idx_q   <= saved_idx_d;
      irq_q         <= irq_d;
`ifdef PREEMPT_ARB_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.grant         = grant_q;
  assign bus.owner         = owner_q;
  assign bus.mstate        = state_q;
  assign bus.saved_valid   = saved_valid_q;
  assign bus.saved_idx     = saved_idx_q;
  assign bus.nb_interrupts = irq_q;

endmodule

// File: doc/preempt_arbiter.md
# preempt_arbiter

Parametrised N-master bus access controller with one preempting high-priority master (index 0) and arbitrated low-priority masters (indices 1..N_MASTERS-1). It is the generalised successor of the three-master access controller:
- master count and counter width are configurable;
- the minimum grant tenure is configurable;
- a preempted master resumes automatically;
- arbitration among low-priority masters is optionally round-robin.

It sits between the requesting modules and the shared resource, driving a one-hot grant.

## Interface
- N_MASTERS, 3, number of masters (≥2); index 0 is the preemptor
- MIN_HOLD, 2, minimum grant tenure in cycles (≥1); `done` is ignored before it is met
- CNT_W, 8, width of the interrupt counter
- IDX_W, $clog2(N_MASTERS), width of index outputs (derived)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_MASTERS  per-master access request, level
- done  in  N_MASTERS  per-master access-complete strobe
- grant  out  N_MASTERS  one-hot grant, all-zero when idle
- owner  out  IDX_W  index of the granted master (0 when idle)
- mstate  out  2  FSM state encoding: IDLE=0, LO_ACT=1, HI_ACT=2, HI_PRE=3
- saved_valid  out  1  a preempted low-priority master is waiting to resume
- saved_idx  out  IDX_W  index of the preempted master
- nb_interrupts  out  CNT_W  saturating count of preemptions

## Operation
- IDLE:
  - req[0] → HI_ACT, owner 0.
  - Otherwise, any req[N-1:1] → LO_ACT, owner chosen by the picker.
  - No request → stay in IDLE.
- LO_ACT, checked in this order:
  - done[owner] with hold met → if req[0] then HI_ACT, else IDLE. No interrupt is counted; release wins over preemption.
  - Otherwise req[0] → HI_PRE: saved_idx = owner, saved_valid = 1, nb_interrupts += 1 (saturating). Preemption is allowed on any cycle of the tenure, including the first.
- HI_ACT:
  - done[0] with hold met → IDLE.
- HI_PRE:
  - done[0] with hold met and req[saved_idx] high → LO_ACT, owner = saved_idx. The picker is not consulted and the tenure counter restarts.
  - done[0] with hold met and req[saved_idx] low → IDLE.
  - saved_valid clears on either exit.
- Hold rule: a tenure counter starts at 1 on the first grant cycle. `done` is honoured only when the counter ≥ MIN_HOLD. The counter saturates at MIN_HOLD.
- Signals that are ignored:
  - done bits of non-owners;
  - the owner dropping req without done (the grant persists until done);
  - req[0] while in HI_ACT or HI_PRE.
- Arbitration: the picker selects only among low-priority masters. The round-robin pointer (see Configuration) updates on each fresh LO_ACT grant from IDLE, never on a resume.

## Timing
- The FSM and all outputs are registered.
- Latency from req to grant is 1 cycle from IDLE.
- Preemption takes effect 1 cycle after req[0] is sampled.
- Release: grant goes to zero, or to the next owner, on the cycle after the qualifying done.
- Minimum tenure is MIN_HOLD cycles, including a resumed tenure.
- Reset (asynchronous, any time, including mid-preemption):
  - grant=0, owner=0, mstate=IDLE;
  - saved_valid=0, saved_idx=0, nb_interrupts=0;
  - round-robin pointer = 1.
- There are no combinational paths from inputs to outputs.

## Configuration
- PREEMPT_ARB_RR_EN defined: low-priority masters are picked round-robin. The search starts at the index after the last freshly granted low master and wraps from N_MASTERS-1 to 1.
- PREEMPT_ARB_RR_EN undefined: fixed priority, where the lowest requesting index in 1..N_MASTERS-1 wins. No pointer register exists.

## Structure
- The package preempt_arb_pkg holds:
  - the state enum typedef (IDLE, LO_ACT, HI_ACT, HI_PRE);
  - the state width constant.
- Sub-module arb_pick: combinational selector taking req[N-1:1] and the pointer. It returns valid and an index, in either round-robin or fixed mode depending on the macro.
- The top level holds the FSM, tenure counter, saved-master register and interrupt counter.

## Test plan
All scenarios use N_MASTERS=3 and MIN_HOLD=2 unless stated.

- Basic grant and hold: reset, then req=3'b010.
  - Next cycle: grant=3'b010, owner=1.
  - done[1] on the first grant cycle is ignored.
  - done[1] on the second grant cycle → grant=0, mstate=IDLE.
- Preempt and resume: master 1 is granted, then req[0] is asserted on its first cycle.
  - Next cycle: grant=3'b001, mstate=HI_PRE, saved_idx=1, nb_interrupts=1.
  - done[0] after 2 cycles with req[1] still high → grant=3'b010, saved_valid=0.
- Simultaneous events: in LO_ACT with hold met, done[1] and req[0] arrive together.
  - Result: grant=3'b001, mstate=HI_ACT, nb_interrupts unchanged.
- Arbitration mode: req=3'b110 held, with each owner releasing after 2 cycles.
  - With PREEMPT_ARB_RR_EN: grants 010, 100, 010.
  - Without it: 010, 010, 010.
- Saturation: CNT_W=2, five preemptions → nb_interrupts reads 1, 2, 3, 3, 3.
- Asynchronous reset: assert reset mid-cycle during HI_PRE.
  - All outputs go to their reset values before the next clock edge.
  - A fresh req=3'b100 after release is granted normally.
